// File: rtl/truth_table_probe_if.sv
// Signal bundle between a truth_table_probe and the logic that requests sweeps
// and supplies the device-under-probe output.
interface truth_table_probe_if;
  logic       start;
  logic [7:0] expected;
  logic       probe_in1;
  logic       probe_in2;
  logic       probe_in3;
  logic       probe_out;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic       match;
  logic [7:0] mismatch_mask;

  modport master (
    output start, expected, probe_out,
    input  probe_in1, probe_in2, probe_in3, busy, done, code, match, mismatch_mask
  );

  modport slave (
    input  start, expected, probe_out,
    output probe_in1, probe_in2, probe_in3, busy, done, code, match, mismatch_mask
  );
endinterface

// File: rtl/truth_table_probe.sv
// Sweeps all eight input combinations of a 3-input block, samples its output
// after SETTLE extra cycles each, and reports the recovered 8-bit function code.
module truth_table_probe #(
  parameter int unsigned SETTLE = 2
) (
  input logic               clk,
  input logic               reset,
  truth_table_probe_if.slave bus
);
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_t;

  state_t     state_q, state_d;
  logic [2:0] index_q;
  logic [3:0] cnt_q;
  logic [7:0] exp_q;
  logic [7:0] cap_q;
  logic [7:0] cap_full;
  logic [7:0] code_q;
  logic       match_q;
  logic [7:0] mask_q;
  logic       load;
  logic       sample;
  logic       last;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A start seen in REPORT goes straight to SWEEP so back-to-back sweeps
  // are spaced 8*(SETTLE+1)+1 cycles apart.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = (state_q == SWEEP) && (cnt_q == '0);
    last    = sample && (index_q == 3'd7);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          load    = 1'b1;
        end
      end
      SWEEP: begin
        if (last) state_d = REPORT;
      end
      REPORT: begin
        if (bus.start) begin
          state_d = SWEEP;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_full          = cap_q;
    cap_full[index_q] = bus.probe_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      code_q  <= '0;
      match_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      if (load) begin
        index_q <= '0;
        cnt_q   <= SETTLE_L;
        exp_q   <= bus.expected;
        cap_q   <= '0;
      end else if (state_q == SWEEP) begin
        if (sample) begin
          cap_q <= cap_full;
          if (index_q != 3'd7) begin
            index_q <= index_q + 3'd1;
            cnt_q   <= SETTLE_L;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
      // Results are taken from the merged capture so they are valid during done.
      if (last) begin
        code_q  <= cap_full;
        match_q <= (cap_full == exp_q);
        mask_q  <= cap_full ^ exp_q;
      end
    end
  end

  always_comb begin
    bus.busy          = (state_q == SWEEP);
    bus.done          = (state_q == REPORT);
    bus.probe_in1     = (state_q == SWEEP) ? index_q[2] : 1'b0;
    bus.probe_in2     = (state_q == SWEEP) ? index_q[1] : 1'b0;
    bus.probe_in3     = (state_q == SWEEP) ? index_q[0] : 1'b0;
    bus.code          = code_q;
    bus.match         = match_q;
    bus.mismatch_mask = mask_q;
  end
endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: one probe with SETTLE=2 and one with
// SETTLE=0, each driving its own model of the block being characterized.
module tb_truth_table_probe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mode;        // 0: combinational 0x99, 1: constant 1, 2: 0x99 with 2-cycle latency
  logic [7:0] func;
  logic [2:0] idx2, idx0;
  logic r1_2, r2_2, r1_0, r2_0;

  truth_table_probe_if bus2 ();
  truth_table_probe_if bus0 ();

  truth_table_probe #(.SETTLE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  truth_table_probe #(.SETTLE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  assign idx2 = {bus2.probe_in1, bus2.probe_in2, bus2.probe_in3};
  assign idx0 = {bus0.probe_in1, bus0.probe_in2, bus0.probe_in3};
  assign bus2.probe_out = (mode == 1) ? 1'b1 : (mode == 2) ? r2_2 : func[idx2];
  assign bus0.probe_out = (mode == 1) ? 1'b1 : (mode == 2) ? r2_0 : func[idx0];

  always @(posedge clk) begin
    r1_2 <= func[idx2];
    r2_2 <= r1_2;
    r1_0 <= func[idx0];
    r2_0 <= r1_0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Returns just after the accepted edge E0; expected is then scrambled.
  task automatic start_pulse(input int which, input logic [7:0] exp);
    @(negedge clk);
    if (which == 2) begin bus2.start = 1'b1; bus2.expected = exp; end
    else            begin bus0.start = 1'b1; bus0.expected = exp; end
    @(posedge clk);
    #1;
    if (which == 2) begin bus2.start = 1'b0; bus2.expected = ~exp; end
    else            begin bus0.start = 1'b0; bus0.expected = ~exp; end
  endtask

  task automatic run_sweep(input int which, input logic [7:0] exp, input int lat);
    int seen;
    logic d;
    seen = -1;
    start_pulse(which, exp);
    for (int k = 1; k <= lat + 5; k++) begin
      @(posedge clk);
      #1;
      d = (which == 2) ? bus2.done : bus0.done;
      if (d) begin
        seen = k;
        break;
      end
    end
    check("done_latency", seen, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    checks = 0;
    errors = 0;
    mode = 0;
    func = 8'h99;
    reset = 1'b1;
    bus2.start = 1'b0; bus2.expected = '0;
    bus0.start = 1'b0; bus0.expected = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus2.busy, 0);
    check("rst_done", bus2.done, 0);
    check("rst_probe", idx2, 0);
    check("rst_code", bus2.code, 8'h00);
    check("rst_match", bus2.match, 0);
    check("rst_mask", bus2.mismatch_mask, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Sweep 0x99 with matching expected, cycle by cycle.
    start_pulse(2, 8'h99);
    check("t1_busy_e0", bus2.busy, 1);
    check("t1_probe_e0", idx2, 0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      check("t1_done", bus2.done, (k == 24));
      check("t1_busy", bus2.busy, (k < 24));
      check("t1_probe", idx2, (k < 24) ? k / 3 : 0);
      if (k < 24) check("t1_code_hold", bus2.code, 8'h00);
      if (k == 24) begin
        check("t1_code", bus2.code, 8'h99);
        check("t1_match", bus2.match, 1);
        check("t1_mask", bus2.mismatch_mask, 8'h00);
      end
    end

    run_sweep(2, 8'h96, 24);
    check("t2_code", bus2.code, 8'h99);
    check("t2_match", bus2.match, 0);
    check("t2_mask", bus2.mismatch_mask, 8'h0F);

    mode = 1;
    run_sweep(2, 8'hFF, 24);
    check("t3_code", bus2.code, 8'hFF);
    check("t3_match", bus2.match, 1);

    // Reset sampled at E0+10 aborts the sweep.
    mode = 0;
    start_pulse(2, 8'h99);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t4_busy", bus2.busy, 0);
    check("t4_probe", idx2, 0);
    check("t4_code", bus2.code, 8'h00);
    check("t4_match", bus2.match, 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus2.done) dones++;
    end
    check("t4_no_done", dones, 0);

    // start held high: the second sweep is accepted on the edge ending done.
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.expected = 8'h99;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
      check("t5_done", bus2.done, (k == 24) || (k == 49));
      if (k == 25) check("t5_busy_restart", bus2.busy, 1);
      if (bus2.busy && bus2.done) check("t5_busy_and_done", 1, 0);
    end
    bus2.start = 1'b0;
    check("t5_code", bus2.code, 8'h99);
    @(posedge clk);
    #1;
    check("t5_idle_busy", bus2.busy, 0);
    check("t5_idle_done", bus2.done, 0);

    // Device with 2-cycle output latency.
    mode = 2;
    repeat (4) @(posedge clk);
    run_sweep(2, 8'h99, 24);
    check("t6_s2_code", bus2.code, 8'h99);
    check("t6_s2_match", bus2.match, 1);
    run_sweep(0, 8'h99, 8);
    check("t6_s0_code", bus0.code, 8'h67);
    check("t6_s0_match", bus0.match, 0);
    check("t6_s0_mask", bus0.mismatch_mask, 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
